// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: exception-zip layout and load-op one-hot indices.
package mem_stage_pkg;

  localparam int unsigned EX_ZIP_W = 86;

  // Exception zip bit positions, ale at bit 0
  localparam int unsigned ZIP_ALE        = 0;
  localparam int unsigned ZIP_INE        = 1;
  localparam int unsigned ZIP_BRK        = 2;
  localparam int unsigned ZIP_SYS        = 3;
  localparam int unsigned ZIP_ADEF       = 4;
  localparam int unsigned ZIP_HAS_INT    = 5;
  localparam int unsigned ZIP_ERTN       = 6;
  localparam int unsigned ZIP_CSR_NUM    = 7;   // 14 bits
  localparam int unsigned ZIP_CSR_WVALUE = 21;  // 32 bits
  localparam int unsigned ZIP_CSR_WMASK  = 53;  // 32 bits
  localparam int unsigned ZIP_CSR_WE     = 85;

  // One-hot load op indices within {ld_w, ld_hu, ld_h, ld_bu, ld_b}
  localparam int unsigned LD_OP_W = 5;
  localparam int unsigned LD_B    = 0;
  localparam int unsigned LD_BU   = 1;
  localparam int unsigned LD_H    = 2;
  localparam int unsigned LD_HU   = 3;
  localparam int unsigned LD_W    = 4;

endpackage

// File: rtl/mem_stage_load_extract.sv
// Combinational load-data extraction: selects byte/half/word by address offset and extends.
module load_extract
  import mem_stage_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [1:0]         addr,
  input  logic [31:0]        rdata,
  output logic [31:0]        data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, then extend according to the one-hot op
  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    unique case (1'b1)
      ld_op[LD_B]:  data = {{24{byte_sel[7]}}, byte_sel};
      ld_op[LD_BU]: data = {24'd0, byte_sel};
      ld_op[LD_H]:  data = {{16{half_sel[15]}}, half_sel};
      ld_op[LD_HU]: data = {16'd0, half_sel};
      ld_op[LD_W]:  data = rdata;
      default:      data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for the data-SRAM response of
// loads/stores, extends load data and hands the result to WB via valid/allowin.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  output logic                ms_allowin,
  input  logic                es_to_ms_valid,
  input  logic [31:0]         es_pc,
  input  logic [31:0]         es_alu_result,
  input  logic [4:0]          es_rf_waddr,
  input  logic                es_rf_we,
  input  logic                es_res_from_mem,
  input  logic [LD_OP_W-1:0]  es_ld_op,
  input  logic                es_mem_req,
  input  logic                es_csr_re,
  input  logic [EX_ZIP_W-1:0] es_ex_zip,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                ws_allowin,
  input  logic                wb_ex,
  input  logic                ertn_flush,
  output logic                ms_to_ws_valid,
  output logic [31:0]         ms_pc,
  output logic [31:0]         ms_rf_wdata,
  output logic [4:0]          ms_rf_waddr,
  output logic                ms_rf_we,
  output logic                ms_csr_re,
  output logic [EX_ZIP_W-1:0] ms_ex_zip,
  output logic [31:0]         ms_result,
  output logic                ms_fwd_we,
  output logic [4:0]          ms_fwd_waddr,
  output logic [31:0]         ms_fwd_wdata,
  output logic                ms_ld_blk,
  output logic                ms_csr_blk,
  output logic                ms_ex_flag
);

  logic                ms_valid_q;
  logic                pending_q;
  logic                drop_q;
  logic [31:0]         pc_q;
  logic [31:0]         alu_result_q;
  logic [4:0]          rf_waddr_q;
  logic                rf_we_q;
  logic                res_from_mem_q;
  logic [LD_OP_W-1:0]  ld_op_q;
  logic                csr_re_q;
  logic [EX_ZIP_W-1:0] ex_zip_q;
  logic [31:0]         rdata_q;

  logic        flush;
  logic        ready_go;
  logic        capture;
  logic [31:0] rdata_cur;
  logic [31:0] load_data;

  // Handshake and stall decode
  always_comb begin
    flush          = wb_ex | ertn_flush;
    ready_go       = ~pending_q | data_sram_data_ok;
    // A swallowed response is still outstanding while drop is set
    ms_allowin     = ~drop_q & (~ms_valid_q | (ready_go & ws_allowin));
    capture        = es_to_ms_valid & ms_allowin;
    ms_to_ws_valid = ms_valid_q & ready_go & ~flush;
    rdata_cur      = data_sram_data_ok ? data_sram_rdata : rdata_q;
  end

  load_extract u_load_extract (
    .ld_op (ld_op_q),
    .addr  (alu_result_q[1:0]),
    .rdata (rdata_cur),
    .data  (load_data)
  );

  // Stage valid, outstanding-response tracking and response-data latch
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      if (flush) begin
        ms_valid_q <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid_q <= es_to_ms_valid;
      end

      if (flush && ms_valid_q && pending_q && !data_sram_data_ok) begin
        pending_q <= 1'b0;
        drop_q    <= 1'b1;
      end else begin
        // A data_ok coinciding with a new capture belongs to the older request
        if (capture && es_mem_req) begin
          pending_q <= 1'b1;
        end else if (data_sram_data_ok) begin
          pending_q <= 1'b0;
        end
        if (data_sram_data_ok) begin
          drop_q <= 1'b0;
        end
      end

      if (data_sram_data_ok) begin
        rdata_q <= data_sram_rdata;
      end
    end
  end

  // Pipeline register capture from EX
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q           <= 32'd0;
      alu_result_q   <= 32'd0;
      rf_waddr_q     <= 5'd0;
      rf_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      ld_op_q        <= '0;
      csr_re_q       <= 1'b0;
      ex_zip_q       <= '0;
    end else if (capture) begin
      pc_q           <= es_pc;
      alu_result_q   <= es_alu_result;
      rf_waddr_q     <= es_rf_waddr;
      rf_we_q        <= es_rf_we;
      res_from_mem_q <= es_res_from_mem;
      ld_op_q        <= es_ld_op;
      csr_re_q       <= es_csr_re;
      ex_zip_q       <= es_ex_zip;
    end
  end

  // Outputs to WB and bypass/blocking info to ID and EX
  always_comb begin
    ms_pc        = pc_q;
    ms_result    = alu_result_q;
    ms_rf_wdata  = res_from_mem_q ? load_data : alu_result_q;
    ms_rf_waddr  = rf_waddr_q;
    ms_rf_we     = rf_we_q;
    ms_csr_re    = csr_re_q;
    ms_ex_zip    = ex_zip_q;
    ms_ex_flag   = ms_valid_q & (|ex_zip_q[ZIP_ERTN:ZIP_ALE]);
    ms_fwd_we    = ms_valid_q & rf_we_q;
    ms_fwd_waddr = rf_waddr_q;
    ms_fwd_wdata = ms_rf_wdata;
    ms_ld_blk    = ms_valid_q & res_from_mem_q & pending_q & ~data_sram_data_ok;
    ms_csr_blk   = ms_valid_q & csr_re_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-instruction vectors plus
// hand-written sequences for WB stall, flush with outstanding response and back-to-back loads.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [31:0] es_alu_result;
  logic [4:0]  es_rf_waddr;
  logic        es_rf_we;
  logic        es_res_from_mem;
  logic [4:0]  es_ld_op;
  logic        es_mem_req;
  logic        es_csr_re;
  logic [85:0] es_ex_zip;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        wb_ex;
  logic        ertn_flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_rf_wdata;
  logic [4:0]  ms_rf_waddr;
  logic        ms_rf_we;
  logic        ms_csr_re;
  logic [85:0] ms_ex_zip;
  logic [31:0] ms_result;
  logic        ms_fwd_we;
  logic [4:0]  ms_fwd_waddr;
  logic [31:0] ms_fwd_wdata;
  logic        ms_ld_blk;
  logic        ms_csr_blk;
  logic        ms_ex_flag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_pc             (es_pc),
    .es_alu_result     (es_alu_result),
    .es_rf_waddr       (es_rf_waddr),
    .es_rf_we          (es_rf_we),
    .es_res_from_mem   (es_res_from_mem),
    .es_ld_op          (es_ld_op),
    .es_mem_req        (es_mem_req),
    .es_csr_re         (es_csr_re),
    .es_ex_zip         (es_ex_zip),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .wb_ex             (wb_ex),
    .ertn_flush        (ertn_flush),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_wdata       (ms_rf_wdata),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_rf_we          (ms_rf_we),
    .ms_csr_re         (ms_csr_re),
    .ms_ex_zip         (ms_ex_zip),
    .ms_result         (ms_result),
    .ms_fwd_we         (ms_fwd_we),
    .ms_fwd_waddr      (ms_fwd_waddr),
    .ms_fwd_wdata      (ms_fwd_wdata),
    .ms_ld_blk         (ms_ld_blk),
    .ms_csr_blk        (ms_csr_blk),
    .ms_ex_flag        (ms_ex_flag)
  );

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [4:0]  ld_op;
    logic        res_from_mem;
    logic        mem_req;
    logic        rf_we;
    logic [85:0] zip;
    logic [31:0] rdata;
    int          delay;
    logic        chk_data;
    logic [31:0] exp_wdata;
    logic        exp_ex_flag;
  } vec_t;

  vec_t vecs[9];

  localparam logic [4:0] OP_B  = 5'b00001;
  localparam logic [4:0] OP_BU = 5'b00010;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b01000;
  localparam logic [4:0] OP_W  = 5'b10000;

  task automatic chk(input string name, input logic [85:0] act, input logic [85:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] alu, input logic [4:0] op,
                              input logic rfm, input logic req, input logic we,
                              input logic [85:0] zip, input logic [31:0] rdata, input int delay,
                              input logic chk_data, input logic [31:0] wdata,
                              input logic ex_flag);
    vec_t v;
    v.name = name; v.alu = alu; v.ld_op = op; v.res_from_mem = rfm; v.mem_req = req;
    v.rf_we = we; v.zip = zip; v.rdata = rdata; v.delay = delay; v.chk_data = chk_data;
    v.exp_wdata = wdata; v.exp_ex_flag = ex_flag;
    return v;
  endfunction

  // Present one instruction from EX for a single cycle (call at a negedge)
  task automatic present(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] op,
                         input logic rfm, input logic req, input logic we,
                         input logic [85:0] zip);
    es_to_ms_valid  = 1'b1;
    es_pc           = pc;
    es_alu_result   = alu;
    es_ld_op        = op;
    es_res_from_mem = rfm;
    es_mem_req      = req;
    es_rf_we        = we;
    es_rf_waddr     = 5'd7;
    es_csr_re       = 1'b0;
    es_ex_zip       = zip;
  endtask

  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    @(negedge clk);
    present(pc, v.alu, v.ld_op, v.res_from_mem, v.mem_req, v.rf_we, v.zip);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    if (v.mem_req) begin
      for (int i = 0; i < v.delay; i++) begin
        #1;
        chk({v.name, " ld_blk wait"}, 86'(ms_ld_blk), 86'(v.res_from_mem));
        chk({v.name, " valid wait"}, 86'(ms_to_ws_valid), 86'd0);
        @(negedge clk);
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = v.rdata;
    end
    #1;
    chk({v.name, " to_ws_valid"}, 86'(ms_to_ws_valid), 86'd1);
    chk({v.name, " ld_blk"}, 86'(ms_ld_blk), 86'd0);
    chk({v.name, " ex_flag"}, 86'(ms_ex_flag), 86'(v.exp_ex_flag));
    chk({v.name, " ex_zip"}, ms_ex_zip, v.zip);
    chk({v.name, " result"}, 86'(ms_result), 86'(v.alu));
    chk({v.name, " pc"}, 86'(ms_pc), 86'(pc));
    chk({v.name, " fwd_we"}, 86'(ms_fwd_we), 86'(v.rf_we));
    if (v.chk_data) begin
      chk({v.name, " rf_wdata"}, 86'(ms_rf_wdata), 86'(v.exp_wdata));
      chk({v.name, " fwd_wdata"}, 86'(ms_fwd_wdata), 86'(v.exp_wdata));
    end
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    chk({v.name, " retired"}, 86'(ms_to_ws_valid), 86'd0);
  endtask

  initial begin
    logic [85:0] zip_ale;
    logic [85:0] zip_ertn;
    zip_ale = '0;
    zip_ale[ZIP_ALE] = 1'b1;
    zip_ertn = '0;
    zip_ertn[ZIP_ERTN] = 1'b1;
    zip_ertn[ZIP_CSR_NUM +: 14] = 14'h5;
    zip_ertn[ZIP_CSR_WE] = 1'b1;

    vecs[0] = mk("add",    32'h0000_1234, 5'd0,  0, 0, 1, '0, 32'h0, 0, 1, 32'h0000_1234, 0);
    vecs[1] = mk("ld_b",   32'h0000_1003, OP_B,  1, 1, 1, '0, 32'h80FF_0000, 2, 1,
                 32'hFFFF_FF80, 0);
    vecs[2] = mk("ld_bu",  32'h0000_1003, OP_BU, 1, 1, 1, '0, 32'h80FF_0000, 2, 1,
                 32'h0000_0080, 0);
    vecs[3] = mk("ld_h",   32'h0000_1002, OP_H,  1, 1, 1, '0, 32'h8001_7FFF, 0, 1,
                 32'hFFFF_8001, 0);
    vecs[4] = mk("ld_hu",  32'h0000_1000, OP_HU, 1, 1, 1, '0, 32'h8001_7FFF, 1, 1,
                 32'h0000_7FFF, 0);
    vecs[5] = mk("ld_w",   32'h0000_2000, OP_W,  1, 1, 1, '0, 32'hDEAD_BEEF, 1, 1,
                 32'hDEAD_BEEF, 0);
    vecs[6] = mk("ld_b1",  32'h0000_1001, OP_B,  1, 1, 1, '0, 32'h1234_5678, 0, 1,
                 32'h0000_0056, 0);
    vecs[7] = mk("ale",    32'h0000_1001, OP_W,  1, 0, 1, zip_ale, 32'h0, 0, 0, 32'h0, 1);
    vecs[8] = mk("ertn",   32'h0000_0042, 5'd0,  0, 0, 0, zip_ertn, 32'h0, 0, 1,
                 32'h0000_0042, 1);

    resetn = 1'b0;
    es_to_ms_valid = 1'b0;
    es_pc = '0; es_alu_result = '0; es_rf_waddr = '0; es_rf_we = 1'b0;
    es_res_from_mem = 1'b0; es_ld_op = '0; es_mem_req = 1'b0; es_csr_re = 1'b0;
    es_ex_zip = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    ws_allowin = 1'b1; wb_ex = 1'b0; ertn_flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst allowin", 86'(ms_allowin), 86'd1);
    chk("rst to_ws_valid", 86'(ms_to_ws_valid), 86'd0);
    chk("rst rf_wdata", 86'(ms_rf_wdata), 86'd0);
    chk("rst ex_zip", ms_ex_zip, 86'd0);
    chk("rst blk", 86'({ms_fwd_we, ms_ld_blk, ms_csr_blk, ms_ex_flag}), 86'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], 32'h1c00_0000 + 32'(i) * 4);
    end

    // WB stalls for 3 cycles after the response; latched data must hold
    @(negedge clk);
    present(32'h1c00_0100, 32'h0000_1002, OP_H, 1, 1, 1, '0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8001_7FFF;
    #1;
    chk("stall dok wdata", 86'(ms_rf_wdata), 86'hFFFF_8001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0BAD_0BAD;
      #1;
      chk("stall valid", 86'(ms_to_ws_valid), 86'd1);
      chk("stall allowin", 86'(ms_allowin), 86'd0);
      chk("stall wdata", 86'(ms_rf_wdata), 86'hFFFF_8001);
    end
    @(negedge clk);
    ws_allowin = 1'b1;
    #1;
    chk("stall release allowin", 86'(ms_allowin), 86'd1);
    @(negedge clk);
    #1;
    chk("stall retired", 86'(ms_to_ws_valid), 86'd0);

    // Flush with a response outstanding: response is swallowed, nothing accepted before it
    @(negedge clk);
    present(32'h1c00_0200, 32'h0000_3000, OP_W, 1, 1, 1, '0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    wb_ex = 1'b1;
    #1;
    chk("flush to_ws_valid", 86'(ms_to_ws_valid), 86'd0);
    @(negedge clk);
    wb_ex = 1'b0;
    present(32'h1c00_0204, 32'h0000_0055, 5'd0, 0, 0, 1, '0);
    #1;
    chk("flush drop allowin", 86'(ms_allowin), 86'd0);
    chk("flush valid gone", 86'(ms_fwd_we | ms_to_ws_valid), 86'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hBAD0_BAD0;
    #1;
    chk("flush dok allowin", 86'(ms_allowin), 86'd0);
    chk("flush dok swallowed", 86'(ms_to_ws_valid), 86'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    chk("flush after allowin", 86'(ms_allowin), 86'd1);
    chk("flush after valid", 86'(ms_to_ws_valid), 86'd0);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    chk("flush next valid", 86'(ms_to_ws_valid), 86'd1);
    chk("flush next wdata", 86'(ms_rf_wdata), 86'h55);
    @(negedge clk);
    #1;
    chk("flush next retired", 86'(ms_to_ws_valid), 86'd0);

    // Back-to-back loads: first response arrives as the second is captured
    @(negedge clk);
    present(32'h1c00_0300, 32'h0000_3000, OP_W, 1, 1, 1, '0);
    @(negedge clk);
    present(32'h1c00_0304, 32'h0000_3004, OP_W, 1, 1, 1, '0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1111_1111;
    #1;
    chk("b2b first valid", 86'(ms_to_ws_valid), 86'd1);
    chk("b2b first wdata", 86'(ms_rf_wdata), 86'h1111_1111);
    chk("b2b allowin", 86'(ms_allowin), 86'd1);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    chk("b2b second blk", 86'(ms_ld_blk), 86'd1);
    chk("b2b second wait", 86'(ms_to_ws_valid), 86'd0);
    chk("b2b second pc", 86'(ms_pc), 86'h1c00_0304);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h2222_2222;
    #1;
    chk("b2b second valid", 86'(ms_to_ws_valid), 86'd1);
    chk("b2b second wdata", 86'(ms_rf_wdata), 86'h2222_2222);
    @(negedge clk);
    data_sram_data_ok = 1'b0;
    #1;
    chk("b2b retired", 86'(ms_to_ws_valid), 86'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
